jk_sequence_driver: RTL and testbench

- Drives a bank of external JK flip-flops through an arbitrary, programmable state sequence. This is the counter's next-state logic; the flip-flop bank holds the state.
- Each cycle, the block reads the flip-flops' current Q, looks up the target state in a small sequence table, and produces per-bit J/K excitation (inverse of the JK characteristic).
- Checks that the flip-flops actually reached each expected state and flags divergence.

---
 rtl/jk_sequence_driver.sv | 136 +++++++++++++
 tb/tb_jk_sequence_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/jk_sequence_driver.sv
// jk_sequence_driver: next-state logic for a bank of external JK flops.
// Walks a programmable state table and flags divergence of the flop bank.
module jk_sequence_driver #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             C,
   input  logic             R,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic [AW:0]      seq_len,
   input  logic             run,
   input  logic [WIDTH-1:0] Q_fb,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic [AW-1:0]    idx,
   output logic             busy,
   output logic             wrap,
   output logic             mismatch
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   state_t           state, state_d;
   logic [AW-1:0]    idx_d;
   logic             wrap_d;
   logic             mis_d;
   logic [AW:0]      len, len_d;
   logic [AW:0]      len_in;
   logic [AW:0]      len_m1;
   logic [AW-1:0]    idx_nxt;
   logic             at_last;
   logic             wr_en;
   logic             drive;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] tbl [DEPTH];

   // Out-of-range lengths fall back to the full table.
   assign len_in  = (seq_len == '0 || seq_len > LEN_MAX)
                    ? LEN_MAX : seq_len;
   assign len_m1  = len - (AW+1)'(1);
   assign at_last = (idx == len_m1[AW-1:0]);
   assign idx_nxt = at_last ? '0 : idx + AW'(1);

   // Next-state, handshake flags and excitation target.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      wrap_d  = 1'b0;
      mis_d   = mismatch;
      len_d   = len;
      wr_en   = 1'b0;
      drive   = 1'b0;
      target  = tbl[0];
      unique case (state)
         IDLE: begin
            wr_en = load_en;
            if (run) begin
               state_d = INIT;
               len_d   = len_in;
            end
         end
         INIT: begin
            drive   = 1'b1;
            state_d = RUN;
            idx_d   = '0;
         end
         RUN: begin
            if (!run) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               drive  = 1'b1;
               target = tbl[idx_nxt];
               if (Q_fb != tbl[idx]) begin
                  state_d = ERR;
                  mis_d   = 1'b1;
               end else begin
                  idx_d  = idx_nxt;
                  wrap_d = at_last;
               end
            end
         end
         ERR: begin
            if (!run) begin
               state_d = IDLE;
               mis_d   = 1'b0;
               idx_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Inverse JK characteristic; J=K=1 never produced, flops hold otherwise.
   assign J = (drive && !R) ? (~Q_fb & target) : '0;
   assign K = (drive && !R) ? (Q_fb & ~target) : '0;

   assign busy = (state == INIT) || (state == RUN);

   // Control state register.
   always_ff @(posedge C) begin
      if (R) begin
         state    <= IDLE;
         idx      <= '0;
         wrap     <= 1'b0;
         mismatch <= 1'b0;
         len      <= LEN_MAX;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         wrap     <= wrap_d;
         mismatch <= mis_d;
         len      <= len_d;
      end
   end

   // Sequence table; writable only while idle, cleared by reset.
   always_ff @(posedge C) begin
      if (R) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else if (wr_en) begin
         tbl[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_jk_sequence_driver.sv
// tb_jk_sequence_driver: directed bench with a behavioural JK flop bank.
// Table contents are mirrored locally to derive expected Q/idx/wrap.
module tb_jk_sequence_driver;

   logic       C = 1'b0;
   logic       R;
   logic       load_en;
   logic [2:0] load_addr;
   logic [3:0] load_data;
   logic [3:0] seq_len;
   logic       run;
   logic [3:0] Q_fb;
   logic [3:0] J;
   logic [3:0] K;
   logic [2:0] idx;
   logic       busy;
   logic       wrap;
   logic       mismatch;

   logic [3:0] ff_q = 4'h0;
   logic [3:0] stuck0 = 4'h0;
   logic [3:0] tbm [8];

   int n_vec = 0;
   int n_bad = 0;

   jk_sequence_driver #(.WIDTH(4), .DEPTH(8)) dut (
      .C(C), .R(R), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .seq_len(seq_len), .run(run),
      .Q_fb(Q_fb), .J(J), .K(K), .idx(idx), .busy(busy),
      .wrap(wrap), .mismatch(mismatch)
   );

   always #5 C = ~C;

   // External JK flop bank sharing the clock.
   always @(posedge C) ff_q <= (J & ~ff_q) | (~K & ff_q);

   assign Q_fb = ff_q & ~stuck0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge C);
      @(negedge C);
   endtask

   task automatic load(input logic [2:0] a, input logic [3:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
      tbm[a]    = d;
   endtask

   task automatic start(input logic [3:0] sl);
      seq_len = sl;
      run     = 1'b1;
      tick();
      chk("init_busy", 32'(busy), 1);
      tick();
   endtask

   task automatic run_chk(input int first, input int n, input int len);
      for (int i = first; i < first + n; i++) begin
         int e;
         e = i % len;
         chk("run_idx", 32'(idx), 32'(e));
         chk("run_q", 32'(Q_fb), 32'(tbm[e]));
         chk("run_wrap", 32'(wrap), (i > 0 && e == 0) ? 1 : 0);
         chk("run_mis", 32'(mismatch), 0);
         tick();
      end
   endtask

   task automatic stop();
      run = 1'b0;
      tick();
      chk("stop_busy", 32'(busy), 0);
      chk("stop_idx", 32'(idx), 0);
      chk("stop_wrap", 32'(wrap), 0);
   endtask

   initial begin
      R = 1'b1;
      load_en = 1'b0;
      load_addr = '0;
      load_data = '0;
      seq_len = '0;
      run = 1'b0;
      for (int i = 0; i < 8; i++) tbm[i] = 4'h0;
      tick();
      tick();
      chk("rst_j", 32'(J), 0);
      chk("rst_k", 32'(K), 0);
      R = 1'b0;
      tick();
      chk("rst_idx", 32'(idx), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_mis", 32'(mismatch), 0);

      load(3'd0, 4'h0);
      load(3'd1, 4'h3);
      load(3'd2, 4'h5);
      load(3'd3, 4'h9);
      load(3'd4, 4'hF);

      start(4'd5);
      run_chk(0, 2, 5);
      chk("exc_q", 32'(Q_fb), 32'h5);
      chk("exc_j", 32'(J), 32'h8);
      chk("exc_k", 32'(K), 32'h4);
      run_chk(2, 4, 5);

      stuck0 = 4'b0010;
      tick();
      chk("err_mis", 32'(mismatch), 1);
      chk("err_j", 32'(J), 0);
      chk("err_k", 32'(K), 0);
      chk("err_idx", 32'(idx), 1);
      chk("err_busy", 32'(busy), 0);
      tick();
      chk("err_hold", 32'(mismatch), 1);
      chk("err_idx2", 32'(idx), 1);
      run = 1'b0;
      stuck0 = 4'h0;
      tick();
      chk("err_clr", 32'(mismatch), 0);
      chk("err_idle", 32'(busy), 0);
      chk("err_idx0", 32'(idx), 0);

      start(4'd0);
      run_chk(0, 3, 8);
      load_en = 1'b1;
      load_addr = 3'd5;
      load_data = 4'hE;
      run_chk(3, 1, 8);
      load_en = 1'b0;
      run_chk(4, 6, 8);
      stop();

      load(3'd2, 4'h7);
      start(4'd0);
      run_chk(0, 9, 8);
      stop();

      load(3'd0, 4'hA);
      start(4'd1);
      run_chk(0, 4, 1);
      chk("len1_j", 32'(J), 0);
      chk("len1_k", 32'(K), 0);
      stop();

      start(4'd5);
      run_chk(0, 3, 5);
      R = 1'b1;
      run = 1'b0;
      #1;
      chk("rrun_j", 32'(J), 0);
      chk("rrun_k", 32'(K), 0);
      tick();
      R = 1'b0;
      #1;
      chk("rrun_idx", 32'(idx), 0);
      chk("rrun_busy", 32'(busy), 0);
      chk("rrun_wrap", 32'(wrap), 0);
      chk("rrun_mis", 32'(mismatch), 0);
      for (int i = 0; i < 8; i++) tbm[i] = 4'h0;
      tick();
      start(4'd12);
      run_chk(0, 9, 8);
      stop();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
